// File: rtl/axis_bram_recorder_pkg.sv
// Shared state encodings and sizing helper for the AXI4-Stream to BRAM capture block.
package axis_bram_recorder_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECORD = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  // Number of BRAM byte-write-enable bits for a given word width.
  function automatic int we_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/axis_bram_recorder.sv
// Records a triggered run of cfg_data AXI4-Stream beats into BRAM port A from address 0.
// Optional macro AXIS_BRAM_RECORDER_TLAST_EN adds s_axis_tlast as an early end-of-run marker.
module axis_bram_recorder
  import axis_bram_recorder_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_data,
  input  logic                         trig_flag,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_data,
  output logic                         done_flag,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
`ifdef AXIS_BRAM_RECORDER_TLAST_EN
  input  logic                         s_axis_tlast,
`endif
  output logic                         s_axis_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

  localparam int WE_W = we_width(BRAM_DATA_WIDTH);

  logic [1:0]                 state;
  logic [BRAM_ADDR_WIDTH-1:0] cnt;
  logic [BRAM_ADDR_WIDTH-1:0] cnt_next;
  logic [BRAM_DATA_WIDTH-1:0] sample;
  logic                       last_beat;

  assign s_axis_tready  = 1'b1;
  assign bram_porta_clk = aclk;
  assign bram_porta_rst = ~aresetn;
  assign sts_data       = cnt;
  assign cnt_next       = cnt + 1'b1;

  generate
    if (BRAM_DATA_WIDTH > AXIS_TDATA_WIDTH) begin : g_extend
      assign sample = {{(BRAM_DATA_WIDTH - AXIS_TDATA_WIDTH){1'b0}}, s_axis_tdata};
    end else begin : g_truncate
      assign sample = s_axis_tdata[BRAM_DATA_WIDTH-1:0];
    end
  endgenerate

`ifdef AXIS_BRAM_RECORDER_TLAST_EN
  assign last_beat = s_axis_tlast;
`else
  assign last_beat = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      done_flag         <= 1'b0;
      bram_porta_addr   <= '0;
      bram_porta_wrdata <= '0;
      bram_porta_we     <= '0;
    end else begin
      bram_porta_we <= '0;
      case (state)
        ST_IDLE: begin
          if (trig_flag && (cfg_data != '0)) begin
            cnt       <= '0;
            done_flag <= 1'b0;
            state     <= ST_RECORD;
          end
        end
        ST_RECORD: begin
          if (s_axis_tvalid) begin
            bram_porta_addr   <= cnt;
            bram_porta_wrdata <= sample;
            bram_porta_we     <= {WE_W{1'b1}};
            cnt               <= cnt_next;
            if ((cnt_next >= cfg_data) || last_beat) begin
              done_flag <= 1'b1;
              state     <= ST_DONE;
            end
          end else if (cnt >= cfg_data) begin
            // Limit lowered below the count while idle on the stream: stop without writing.
            done_flag <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_flag <= 1'b1;
          if (!trig_flag) state <= ST_WAIT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
